uart_fifo_link: RTL and testbench
=================================

UART_FIFO_LINK -- requirements
Module: uart_fifo_link

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning line rate in bit/s.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, legal range 5..8, meaning data bits per frame.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-005 The block SHALL have parameter RX_DEPTH, default 16, power of two and at least 2, meaning RX FIFO entries.
REQ-006 The block SHALL have one clock and a synchronous, active-low reset, with the following ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- rxd  in  1  serial receive line; asynchronous, idle high.
- txd  out  1  serial transmit line; idle high.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  transmitter can accept.
- rx_data  out  DATA_BITS  FIFO head.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer pops head.
- rx_count  out  clog2(RX_DEPTH)+1  FIFO occupancy.
- frame_err  out  1  one-cycle pulse.
- parity_err  out  1  one-cycle pulse.
- overflow  out  1  sticky flag.
- clear_err  in  1  clears overflow.

Function
REQ-007 The block SHALL generate a tick every OSR clocks, where OSR = CLK_HZ/(BAUD*16), truncated and minimum 1; one bit time SHALL equal 16 ticks.
REQ-008 The block SHALL pass rxd through a two-flop synchroniser before any use.
REQ-009 The RX FSM SHALL have states IDLE, START, DATA, PAR and STOP, and SHALL leave IDLE on a synchronised high-to-low transition.
REQ-010 In START, the FSM SHALL re-sample after 8 ticks; if the line is high it SHALL return to IDLE (glitch rejected, no error).
REQ-011 The block SHALL sample data bits LSB first at 16-tick intervals (mid-bit); PAR SHALL be entered only when PARITY != 0.
REQ-012 A STOP sample of 0 SHALL pulse frame_err, discard the byte, and hold the FSM until the line is high before it returns to IDLE.
REQ-013 A parity mismatch SHALL pulse parity_err and discard the byte; if both errors occur, only frame_err SHALL pulse.
REQ-014 A good byte SHALL be pushed into the FIFO on the cycle the stop bit is sampled.
REQ-015 The FIFO SHALL be first-word-fall-through: rx_valid = (rx_count != 0), and rx_data = head.
REQ-016 A pop SHALL occur when rx_valid && rx_ready; pointers SHALL wrap modulo RX_DEPTH.
REQ-017 A push while full with no pop SHALL drop the byte and set overflow; a simultaneous push and pop while full SHALL accept both, leaving rx_count unchanged.
REQ-018 overflow SHALL remain set until clear_err or reset; if clear_err and a new overflow coincide, overflow SHALL stay set.
REQ-019 The TX handshake SHALL complete when tx_valid && tx_ready; tx_ready SHALL go low the next cycle.
REQ-020 txd SHALL fall the cycle after handshake; each bit SHALL last exactly 16*OSR clocks.
REQ-021 The TX frame SHALL be: start 0, data LSB first, optional parity bit, one stop bit of 1.
REQ-022 tx_ready SHALL reassert on the cycle after the stop bit ends, so back-to-back frames carry no idle gap.
REQ-023 tx_data SHALL be registered at handshake; later changes SHALL NOT affect the frame in flight.

Reset
REQ-024 While rst_n = 0 at a clock edge, the block SHALL set: txd = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, rx_count = 0, frame_err = 0, parity_err = 0, overflow = 0.
REQ-025 Reset SHALL return both FSMs to IDLE and clear the tick counter and FIFO pointers.
REQ-026 A reset during a frame SHALL abort the frame without an error pulse; txd SHALL be 1 on the next clock.

Verification (CLK_HZ = 1_600_000, BAUD = 10_000, so OSR = 10 and one bit = 160 clocks)
REQ-027 Drive 8N1 frame 0x41 on rxd -> rx_valid = 1, rx_data = 0x41, rx_count = 1, no error pulses.
REQ-028 PARITY = 1; send 0x03 with parity bit 1 -> one parity_err pulse, rx_count stays 0.
REQ-029 RX_DEPTH = 16, rx_ready = 0; send 17 bytes 0x00..0x10 -> rx_count = 16, overflow = 1, first pop returns 0x00; a clear_err pulse then gives overflow = 0.
REQ-030 Handshake tx_data = 0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 160 clocks; tx_ready low for exactly 1600 clocks.
REQ-031 Send a frame with stop bit 0 -> one frame_err pulse, no push; rxd held low for 50 clocks then high -> no byte, no error.
REQ-032 Assert rst_n = 0 mid-way through a TX frame -> txd = 1 and tx_ready = 1 on the next clock; the next tx_valid starts a fresh frame.

Source files
------------

// File: rtl/uart_fifo_link.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_link
// Description : Full-duplex UART with 16x oversampled receiver feeding a
//               first-word-fall-through RX FIFO, plus a handshaked transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_link #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int RX_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd,
    output logic                          txd,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(RX_DEPTH):0]     rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    input  logic                          clear_err
);

    localparam int   c_osr_raw  = CLK_HZ / (BAUD * 16);
    localparam int   c_osr      = (c_osr_raw < 1) ? 1 : c_osr_raw;
    localparam int   c_osr_w    = (c_osr > 1) ? $clog2(c_osr) : 1;
    localparam int   c_bit_clks = 16 * c_osr;
    localparam int   c_bit_w    = $clog2(c_bit_clks);
    localparam int   c_aw       = $clog2(RX_DEPTH);
    localparam int   c_idx_w    = $clog2(DATA_BITS);
    localparam logic c_odd      = (PARITY == 2);
    localparam logic c_par_en   = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Oversampling tick and input synchroniser
    // ------------------------------------------------------------------
    logic [c_osr_w-1:0] r_osr_cnt;
    logic               r_tick;
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_osr_cnt <= '0;
            r_tick    <= 1'b0;
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            if (r_osr_cnt == c_osr_w'(c_osr - 1)) begin
                r_osr_cnt <= '0;
                r_tick    <= 1'b1;
            end else begin
                r_osr_cnt <= r_osr_cnt + 1'b1;
                r_tick    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_t               r_rx_state;
    logic [3:0]           r_rx_ticks;
    logic [c_idx_w-1:0]   r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_bit;
    logic                 r_rx_hold;
    logic                 r_frame_err;
    logic                 r_parity_err;

    logic w_par_bad;
    logic w_stop_sample;
    logic w_push;

    assign w_par_bad     = c_par_en && (r_rx_par_bit != ((^r_rx_shift) ^ c_odd));
    assign w_stop_sample = (r_rx_state == ST_STOP) && !r_rx_hold && r_tick && (r_rx_ticks == 4'd15);
    assign w_push        = w_stop_sample && r_rx_sync && !w_par_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_state   <= ST_IDLE;
            r_rx_ticks   <= '0;
            r_rx_idx     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bit <= 1'b0;
            r_rx_hold    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_rx_state)
                ST_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= ST_START;
                        r_rx_ticks <= '0;
                    end
                end
                ST_START: begin
                    if (r_tick) begin
                        if (r_rx_ticks == 4'd7) begin
                            r_rx_ticks <= '0;
                            r_rx_idx   <= '0;
                            r_rx_state <= r_rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            r_rx_ticks <= r_rx_ticks + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (r_tick) begin
                        r_rx_ticks <= r_rx_ticks + 4'd1;
                        if (r_rx_ticks == 4'd15) begin
                            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                            if (r_rx_idx == c_idx_w'(DATA_BITS - 1))
                                r_rx_state <= c_par_en ? ST_PAR : ST_STOP;
                            else
                                r_rx_idx <= r_rx_idx + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (r_tick) begin
                        r_rx_ticks <= r_rx_ticks + 4'd1;
                        if (r_rx_ticks == 4'd15) begin
                            r_rx_par_bit <= r_rx_sync;
                            r_rx_state   <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    // A low stop bit may be a break; wait for idle before rearming
                    if (r_rx_hold) begin
                        if (r_rx_sync) begin
                            r_rx_hold  <= 1'b0;
                            r_rx_state <= ST_IDLE;
                        end
                    end else if (r_tick) begin
                        r_rx_ticks <= r_rx_ticks + 4'd1;
                        if (r_rx_ticks == 4'd15) begin
                            if (!r_rx_sync) begin
                                r_frame_err <= 1'b1;
                                r_rx_hold   <= 1'b1;
                            end else begin
                                r_parity_err <= w_par_bad;
                                r_rx_state   <= ST_IDLE;
                            end
                        end
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;

    // ------------------------------------------------------------------
    // RX FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [RX_DEPTH];
    logic [c_aw-1:0]      r_wr_ptr;
    logic [c_aw-1:0]      r_rd_ptr;
    logic [c_aw:0]        r_count;
    logic                 r_overflow;

    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_ovf;

    assign w_full = (r_count == (c_aw + 1)'(RX_DEPTH));
    assign w_pop  = rx_valid && rx_ready;
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_ovf  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= r_rx_shift;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf)
                r_overflow <= 1'b1;
            else if (clear_err)
                r_overflow <= 1'b0;
        end
    end

    assign rx_count = r_count;
    assign rx_valid = (r_count != '0);
    assign rx_data  = rx_valid ? r_mem[r_rd_ptr] : '0;
    assign overflow = r_overflow;

    // ------------------------------------------------------------------
    // Transmitter: bit timing counted directly in clocks so the frame is
    // aligned to the handshake rather than to the free-running tick
    // ------------------------------------------------------------------
    state_t               r_tx_state;
    logic [c_bit_w-1:0]   r_tx_cnt;
    logic [c_idx_w-1:0]   r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_txd;
    logic                 r_tx_ready;

    logic w_bit_end;
    assign w_bit_end = (r_tx_cnt == c_bit_w'(c_bit_clks - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_ready <= 1'b1;
        end else begin
            if (r_tx_state != ST_IDLE)
                r_tx_cnt <= w_bit_end ? '0 : r_tx_cnt + 1'b1;
            case (r_tx_state)
                ST_IDLE: begin
                    if (tx_valid && r_tx_ready) begin
                        r_tx_shift <= tx_data;
                        r_tx_par   <= (^tx_data) ^ c_odd;
                        r_txd      <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_idx   <= '0;
                        r_tx_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_tx_idx == c_idx_w'(DATA_BITS - 1)) begin
                            r_txd      <= c_par_en ? r_tx_par : 1'b1;
                            r_tx_state <= c_par_en ? ST_PAR : ST_STOP;
                        end else begin
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_idx   <= r_tx_idx + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_bit_end) begin
                        r_txd      <= 1'b1;
                        r_tx_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_tx_ready <= 1'b1;
                        r_tx_state <= ST_IDLE;
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    assign txd      = r_txd;
    assign tx_ready = r_tx_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo_link
// Description : Directed self-checking bench for uart_fifo_link (8N1 and 8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_link;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic       txd_a, txd_b;
    logic [7:0] tx_data_a = '0, tx_data_b = '0;
    logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0;
    logic       tx_ready_a, tx_ready_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       rx_ready_a = 1'b0, rx_ready_b = 1'b0;
    logic [4:0] rx_count_a, rx_count_b;
    logic       frame_err_a, frame_err_b, parity_err_a, parity_err_b;
    logic       overflow_a, overflow_b;
    logic       clear_err_a = 1'b0, clear_err_b = 1'b0;

    int errors = 0;
    int checks = 0;
    int nf_a = 0, np_a = 0, nf_b = 0, np_b = 0;

    always #5 clk = ~clk;

    uart_fifo_link #(.CLK_HZ(1_600_000), .BAUD(10_000), .DATA_BITS(8), .PARITY(0), .RX_DEPTH(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .txd(txd_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_count(rx_count_a),
        .frame_err(frame_err_a), .parity_err(parity_err_a), .overflow(overflow_a), .clear_err(clear_err_a)
    );

    uart_fifo_link #(.CLK_HZ(1_600_000), .BAUD(10_000), .DATA_BITS(8), .PARITY(1), .RX_DEPTH(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .txd(txd_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_count(rx_count_b),
        .frame_err(frame_err_b), .parity_err(parity_err_b), .overflow(overflow_b), .clear_err(clear_err_b)
    );

    always @(posedge clk) begin
        if (frame_err_a === 1'b1)  nf_a++;
        if (parity_err_a === 1'b1) np_a++;
        if (frame_err_b === 1'b1)  nf_b++;
        if (parity_err_b === 1'b1) np_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit sel_b, input logic v);
        @(negedge clk);
        if (sel_b) rxd_b = v; else rxd_a = v;
        repeat (159) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel_b, input logic [7:0] b, input bit use_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(sel_b, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel_b, b[i]);
        if (use_par) drive_bit(sel_b, par_bit);
        drive_bit(sel_b, stop_bit);
        repeat (5) @(negedge clk);
    endtask

    task automatic pop_a();
        @(negedge clk);
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
    endtask

    task automatic tx_handshake(input logic [7:0] d);
        @(negedge clk);
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        @(posedge clk);
        #1;
        tx_valid_a = 1'b0;
        tx_data_a  = 8'hFF;
    endtask

    initial begin : main
        logic [9:0] exp_frame;
        int         ready_c;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd_a, 1);
        check("rst_tx_ready", tx_ready_a, 1);
        check("rst_rx_valid", rx_valid_a, 0);
        check("rst_rx_data", rx_data_a, 0);
        check("rst_rx_count", rx_count_a, 0);
        check("rst_frame_err", frame_err_a, 0);
        check("rst_parity_err", parity_err_a, 0);
        check("rst_overflow", overflow_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Good 8N1 byte
        send_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b1);
        check("rx41_valid", rx_valid_a, 1);
        check("rx41_data", rx_data_a, 8'h41);
        check("rx41_count", rx_count_a, 1);
        check("rx41_ferr", nf_a, 0);
        check("rx41_perr", np_a, 0);
        pop_a();
        check("rx41_pop_count", rx_count_a, 0);

        // Even parity: wrong and right parity bit for 0x03
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        check("par_bad_perr", np_b, 1);
        check("par_bad_count", rx_count_b, 0);
        check("par_bad_ferr", nf_b, 0);
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        check("par_ok_count", rx_count_b, 1);
        check("par_ok_data", rx_data_b, 8'h03);
        check("par_ok_perr", np_b, 1);

        // Framing error, then a short glitch, then recovery
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rxd_a = 1'b1;
        repeat (320) @(negedge clk);
        check("ferr_count_pulses", nf_a, 1);
        check("ferr_rx_count", rx_count_a, 0);
        check("ferr_perr", np_a, 0);
        rxd_a = 1'b0;
        repeat (50) @(negedge clk);
        rxd_a = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_ferr", nf_a, 1);
        check("glitch_count", rx_count_a, 0);
        send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
        check("recover_count", rx_count_a, 1);
        check("recover_data", rx_data_a, 8'h7E);
        pop_a();

        // Overflow: 17 bytes into 16 entries
        for (int k = 0; k <= 16; k++) send_frame(1'b0, 8'(k), 1'b0, 1'b0, 1'b1);
        check("ovf_count", rx_count_a, 16);
        check("ovf_flag", overflow_a, 1);
        check("ovf_head", rx_data_a, 8'h00);
        pop_a();
        check("ovf_pop_count", rx_count_a, 15);
        check("ovf_sticky", overflow_a, 1);
        @(negedge clk);
        clear_err_a = 1'b1;
        @(negedge clk);
        clear_err_a = 1'b0;
        check("ovf_cleared", overflow_a, 0);
        for (int k = 1; k <= 15; k++) begin
            check("ovf_drain_data", rx_data_a, k);
            pop_a();
        end
        check("ovf_drained", rx_count_a, 0);

        // TX 0xA5 frame timing
        exp_frame = {1'b1, 8'hA5, 1'b0};
        tx_handshake(8'hA5);
        check("tx_ready_drop", tx_ready_a, 0);
        check("tx_start_fall", txd_a, 0);
        ready_c = -1;
        for (int c = 1; c <= 1700; c++) begin
            @(posedge clk);
            #1;
            if (c % 160 == 80 && c < 1600) check("tx_bit", txd_a, exp_frame[c / 160]);
            if (c == 159) check("tx_start_end", txd_a, 0);
            if (c == 160) check("tx_bit0_begin", txd_a, 1);
            if (tx_ready_a === 1'b1) begin
                ready_c = c;
                break;
            end
        end
        check("tx_ready_low_clks", ready_c, 1600);
        check("tx_idle_high", txd_a, 1);

        // Reset in the middle of a TX frame, then a fresh frame
        tx_handshake(8'h00);
        repeat (299) @(posedge clk);
        #1;
        check("txrst_mid_low", txd_a, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("txrst_txd", txd_a, 1);
        check("txrst_ready", tx_ready_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tx_handshake(8'h0F);
        check("txrst_new_start", txd_a, 0);
        check("txrst_new_ready", tx_ready_a, 0);
        repeat (240) @(posedge clk);
        #1;
        check("txrst_new_bit0", txd_a, 1);
        repeat (160 * 4) @(posedge clk);
        #1;
        check("txrst_new_bit4", txd_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
